l2recv: RTL and testbench

Bus receiver for the L2 cache, the partner to the L2 bus transmitter.
- Watches every 8-cycle bus slot and claims fill responses tagged for this L2 (8-beat FLUSH data).
- Buffers each fill and streams it to l2data.
- Queues coherence snoops issued by other agents for l2tag.
- Drives its own contribution to the wired-OR bus nack when it cannot accept a fill or a snoop.

---
 rtl/l2recv_if.sv | 48 ++++
 rtl/l2recv.sv | 128 ++++++++++++
 tb/tb_l2recv.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/l2recv_if.sv
// rtl/l2recv_if.sv - L2 bus receiver port bundle: bus slot inputs, fill stream, snoop queue.
`ifndef CMD_BUSRD
`define CMD_NONE    3'd0
`define CMD_BUSRD   3'd1
`define CMD_BUSRDX  3'd2
`define CMD_BUSUPGR 3'd3
`define CMD_FLUSH   3'd4
`endif

interface l2recv_if;
    logic        bus_valid;
    logic [2:0]  bus_cmd;
    logic [4:0]  bus_tag;
    logic [25:0] bus_addr;
    logic [63:0] bus_data;
    logic        bus_nack;
    logic        bus_l2_grant;
    logic        l2recv_nack;

    logic        fill_valid;
    logic [2:0]  fill_tag;
    logic [25:0] fill_addr;
    logic [63:0] fill_data;
    logic        fill_last;
    logic        fill_ready;

    logic        snoop_valid;
    logic [2:0]  snoop_cmd;
    logic [4:0]  snoop_tag;
    logic [25:0] snoop_addr;
    logic        snoop_ready;

    modport slave (
        input  bus_valid, bus_cmd, bus_tag, bus_addr, bus_data, bus_nack, bus_l2_grant,
        input  fill_ready, snoop_ready,
        output l2recv_nack,
        output fill_valid, fill_tag, fill_addr, fill_data, fill_last,
        output snoop_valid, snoop_cmd, snoop_tag, snoop_addr
    );

    modport master (
        output bus_valid, bus_cmd, bus_tag, bus_addr, bus_data, bus_nack, bus_l2_grant,
        output fill_ready, snoop_ready,
        input  l2recv_nack,
        input  fill_valid, fill_tag, fill_addr, fill_data, fill_last,
        input  snoop_valid, snoop_cmd, snoop_tag, snoop_addr
    );
endinterface

// File: rtl/l2recv.sv
// rtl/l2recv.sv - L2 bus receiver: claims tagged fills, buffers and streams them, queues snoops.
module l2recv #(
    parameter logic [1:0] BUSID       = 2'd1,
    parameter int         SNOOP_DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    l2recv_if.slave  bus
);
    localparam int            PW       = $clog2(SNOOP_DEPTH);
    localparam logic [PW:0]   FULL_CNT = SNOOP_DEPTH[PW:0];

    logic [2:0]  cyc_r;
    logic        own_r;
    logic        slot_end;
    logic        active;
    logic        fill_hit;
    logic        snoop_hit;

    assign slot_end  = (cyc_r == 3'd7);
    assign active    = bus.bus_valid & ~own_r;
    assign fill_hit  = active && (bus.bus_cmd == `CMD_FLUSH) && (bus.bus_tag[4:3] == BUSID);
    assign snoop_hit = active && ((bus.bus_cmd == `CMD_BUSRD) ||
                                  (bus.bus_cmd == `CMD_BUSRDX) ||
                                  (bus.bus_cmd == `CMD_BUSUPGR));

    // Fill staging and output buffer
    logic [63:0] stage_r [8];
    logic [63:0] beat_r  [8];
    logic [2:0]  tag_r;
    logic [25:0] addr_r;
    logic        out_valid_r;
    logic [2:0]  rd_idx_r;
    logic        commit;

    assign commit = slot_end & fill_hit & ~bus.bus_nack & ~out_valid_r;

    // Snoop FIFO
    logic [33:0]   fifo_mem [SNOOP_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          fifo_full;
    logic          push;
    logic          pop;

    assign fifo_full = (count_r == FULL_CNT);
    assign push      = slot_end & snoop_hit & ~bus.bus_nack & ~fifo_full;
    assign pop       = (count_r != '0) & bus.snoop_ready;

    // Nack uses pre-update state only, so it never feeds back through bus_nack
    assign bus.l2recv_nack = (fill_hit & out_valid_r) | (snoop_hit & fifo_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_r       <= 3'd0;
            own_r       <= 1'b0;
            out_valid_r <= 1'b0;
            rd_idx_r    <= 3'd0;
        end else begin
            cyc_r <= cyc_r + 3'd1;
            if (slot_end) begin
                own_r <= bus.bus_l2_grant;
            end
            if (out_valid_r) begin
                if (bus.fill_ready) begin
                    rd_idx_r <= rd_idx_r + 3'd1;
                    if (rd_idx_r == 3'd7) begin
                        out_valid_r <= 1'b0;
                    end
                end
            end else if (commit) begin
                out_valid_r <= 1'b1;
                rd_idx_r    <= 3'd0;
            end
        end
    end

    // Beat 7 is still on the bus at commit, so it bypasses staging
    always_ff @(posedge clk) begin
        if (fill_hit) begin
            stage_r[cyc_r] <= bus.bus_data;
        end
        if (commit) begin
            for (int i = 0; i < 7; i++) begin
                beat_r[i] <= stage_r[i];
            end
            beat_r[7] <= bus.bus_data;
            tag_r     <= bus.bus_tag[2:0];
            addr_r    <= bus.bus_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (push && !pop) begin
                count_r <= count_r + (PW+1)'(1);
            end else if (pop && !push) begin
                count_r <= count_r - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_r] <= {bus.bus_cmd, bus.bus_tag, bus.bus_addr};
        end
    end

    assign bus.fill_valid = out_valid_r;
    assign bus.fill_tag   = tag_r;
    assign bus.fill_addr  = addr_r;
    assign bus.fill_data  = beat_r[rd_idx_r];
    assign bus.fill_last  = (rd_idx_r == 3'd7);

    assign bus.snoop_valid = (count_r != '0);
    assign {bus.snoop_cmd, bus.snoop_tag, bus.snoop_addr} = fifo_mem[rd_ptr_r];
endmodule

// File: tb/tb_l2recv.sv
// tb/tb_l2recv.sv - Scoreboard bench for l2recv: fills, backpressure, snoop overflow, own slot, nack, reset.
module tb_l2recv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ext_nack = 1'b0;
    always #5 clk = ~clk;

    l2recv_if bif();
    assign bif.bus_nack = bif.l2recv_nack | ext_nack;

    l2recv #(.BUSID(2'd1), .SNOOP_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct packed {
        logic [2:0]  tag;
        logic [25:0] addr;
        logic [63:0] data;
        logic        last;
    } fill_t;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [4:0]  tag;
        logic [25:0] addr;
    } snp_t;

    fill_t fill_q[$];
    snp_t  snp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every accepted beat / popped snoop against the queued expectations
    always @(negedge clk) begin
        if (!rst) begin
            if (bif.fill_valid && bif.fill_ready) begin
                if (fill_q.size() == 0) begin
                    chk("fill_unexpected", 128'(bif.fill_valid), 128'(0));
                end else begin
                    fill_t e;
                    e = fill_q.pop_front();
                    chk("fill_beat", 128'({bif.fill_tag, bif.fill_addr, bif.fill_data, bif.fill_last}), 128'(e));
                end
            end
            if (bif.snoop_valid && bif.snoop_ready) begin
                if (snp_q.size() == 0) begin
                    chk("snoop_unexpected", 128'(bif.snoop_valid), 128'(0));
                end else begin
                    snp_t s;
                    s = snp_q.pop_front();
                    chk("snoop_entry", 128'({bif.snoop_cmd, bif.snoop_tag, bif.snoop_addr}), 128'(s));
                end
            end
        end
    end

    task automatic push_fill(input logic [2:0] tag, input logic [25:0] addr, input logic [63:0] base);
        for (int i = 0; i < 8; i++) begin
            fill_q.push_back('{tag: tag, addr: addr, data: base + 64'(i), last: (i == 7)});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bif.bus_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // One 8-cycle bus slot; checks this block's nack at slot cycle 7
    task automatic slot(input logic v, input logic [2:0] cmd, input logic [4:0] tag,
                        input logic [25:0] addr, input logic [63:0] base, input logic grant,
                        input logic xnack, input logic pop7, input logic exp_nack, input string nm);
        for (int c = 0; c < 8; c++) begin
            bif.bus_valid = v;
            bif.bus_cmd   = cmd;
            bif.bus_tag   = tag;
            bif.bus_addr  = addr;
            bif.bus_data  = base + 64'(c);
            if (c == 7) begin
                bif.bus_l2_grant = grant;
                ext_nack = xnack;
                if (pop7) bif.snoop_ready = 1'b1;
                #1;
                chk(nm, 128'(bif.l2recv_nack), 128'(exp_nack));
            end
            @(posedge clk);
            #1;
        end
        bif.bus_valid    = 1'b0;
        bif.bus_l2_grant = 1'b0;
        ext_nack         = 1'b0;
    endtask

    initial begin
        bif.bus_valid    = 1'b0;
        bif.bus_cmd      = `CMD_NONE;
        bif.bus_tag      = 5'd0;
        bif.bus_addr     = 26'd0;
        bif.bus_data     = 64'd0;
        bif.bus_l2_grant = 1'b0;
        bif.fill_ready   = 1'b0;
        bif.snoop_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fill_valid", 128'(bif.fill_valid), 128'(0));
        chk("rst_snoop_valid", 128'(bif.snoop_valid), 128'(0));
        chk("rst_fill_last", 128'(bif.fill_last), 128'(0));
        chk("rst_nack", 128'(bif.l2recv_nack), 128'(0));
        rst = 1'b0;

        // Basic fill
        bif.fill_ready = 1'b1;
        push_fill(3'd5, 26'h0ABCDE, 64'h0);
        slot(1, `CMD_FLUSH, {2'd1, 3'd5}, 26'h0ABCDE, 64'h0, 0, 0, 0, 0, "t1_nack");
        idle(8);

        // Back-to-back fills with backpressure
        bif.fill_ready = 1'b0;
        push_fill(3'd2, 26'h0000100, 64'hA0);
        slot(1, `CMD_FLUSH, {2'd1, 3'd2}, 26'h0000100, 64'hA0, 0, 0, 0, 0, "t2_first_nack");
        slot(1, `CMD_FLUSH, {2'd1, 3'd3}, 26'h0000200, 64'hB0, 0, 0, 0, 1, "t2_second_nack");
        chk("t2_hold_valid", 128'(bif.fill_valid), 128'(1));
        chk("t2_hold_tag", 128'(bif.fill_tag), 128'(3'd2));
        chk("t2_hold_addr", 128'(bif.fill_addr), 128'(26'h0000100));
        chk("t2_hold_data", 128'(bif.fill_data), 128'(64'hA0));
        bif.fill_ready = 1'b1;
        idle(8);

        // Snoop overflow; third slot nacks even though the head pops at cycle 7
        bif.snoop_ready = 1'b0;
        snp_q.push_back('{cmd: `CMD_BUSRDX, tag: {2'd2, 3'd1}, addr: 26'd1});
        snp_q.push_back('{cmd: `CMD_BUSRDX, tag: {2'd2, 3'd1}, addr: 26'd2});
        slot(1, `CMD_BUSRDX, {2'd2, 3'd1}, 26'd1, 64'h0, 0, 0, 0, 0, "t3_snoop1_nack");
        slot(1, `CMD_BUSRDX, {2'd2, 3'd1}, 26'd2, 64'h0, 0, 0, 0, 0, "t3_snoop2_nack");
        slot(1, `CMD_BUSRDX, {2'd2, 3'd1}, 26'd3, 64'h0, 0, 0, 1, 1, "t3_snoop3_nack");
        idle(8);
        chk("t3_fifo_drained", 128'(bif.snoop_valid), 128'(0));

        // Own slot ignored
        slot(0, `CMD_NONE, 5'd0, 26'd0, 64'h0, 1, 0, 0, 0, "t4_grant_nack");
        slot(1, `CMD_FLUSH, {2'd1, 3'd4}, 26'h0000300, 64'hC0, 0, 0, 0, 0, "t4_own_nack");
        chk("t4_no_fill", 128'(bif.fill_valid), 128'(0));

        // External nack
        slot(1, `CMD_FLUSH, {2'd1, 3'd6}, 26'h0000400, 64'hD0, 0, 1, 0, 0, "t5_fill_nack");
        chk("t5_no_fill", 128'(bif.fill_valid), 128'(0));
        slot(1, `CMD_BUSRD, {2'd0, 3'd2}, 26'h0000500, 64'h0, 0, 1, 0, 0, "t5_snoop_nack");
        chk("t5_no_snoop", 128'(bif.snoop_valid), 128'(0));

        // Reset during beat 3 of a drain, with a snoop queued
        bif.snoop_ready = 1'b0;
        slot(1, `CMD_BUSUPGR, {2'd3, 3'd0}, 26'd7, 64'h0, 0, 0, 0, 0, "t6_snoop_nack");
        push_fill(3'd1, 26'h3FFFFFF, 64'hF0);
        slot(1, `CMD_FLUSH, {2'd1, 3'd1}, 26'h3FFFFFF, 64'hF0, 0, 0, 0, 0, "t6_fill_nack");
        idle(3);
        chk("t6_beat3_data", 128'(bif.fill_data), 128'(64'hF3));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_fill_valid", 128'(bif.fill_valid), 128'(0));
        chk("t6_rst_snoop_valid", 128'(bif.snoop_valid), 128'(0));
        chk("t6_rst_nack", 128'(bif.l2recv_nack), 128'(0));
        fill_q.delete();
        snp_q.delete();
        rst = 1'b0;
        bif.snoop_ready = 1'b1;

        // Slot alignment after reset
        push_fill(3'd7, 26'h1555555, 64'hE0);
        slot(1, `CMD_FLUSH, {2'd1, 3'd7}, 26'h1555555, 64'hE0, 0, 0, 0, 0, "t7_nack");
        idle(8);

        chk("end_fill_q_empty", 128'(fill_q.size()), 128'(0));
        chk("end_snoop_q_empty", 128'(snp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
